// File: rtl/subtractor_pipe.sv
// Two-stage valid/ready pipeline that recovers x = sm - y - cin and flags
// results that fall outside the unsigned W-bit range.
module subtractor_pipe #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:0]   sm,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x,
    output logic         x_zero,
    output logic         range_err,
    output logic [7:0]   err_cnt
);

    logic         s1_vld_q;
    logic [W:0]   sm_q;
    logic [W-1:0] y_q;
    logic         cin_q;

    logic         s2_vld_q;
    logic [W-1:0] x_q;
    logic         x_zero_q;
    logic         range_err_q;
    logic [7:0]   err_cnt_q;

    logic         s2_adv;
    logic         in_xfer;
    logic         out_xfer;
    logic [W+1:0] diff;
    logic [W-1:0] x_d;
    logic         x_zero_d;
    logic         range_err_d;
    logic [7:0]   err_cnt_d;

    // Stage 2 can take new data when it is empty or draining this cycle;
    // stage 1 advances exactly when stage 2 can take it.
    assign s2_adv   = !s2_vld_q || out_ready;
    assign in_ready = !rst && (!s1_vld_q || s2_adv);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = s2_vld_q && out_ready;

    always_comb begin
        diff        = {1'b0, sm_q} - {2'b00, y_q} - {{(W+1){1'b0}}, cin_q};
        // Negative (sign bit) or overflowing past W bits (bit W) is out of range.
        range_err_d = diff[W+1] || diff[W];
        x_d         = diff[W-1:0];
        x_zero_d    = (diff == '0);
        err_cnt_d   = err_cnt_q;
        if (out_xfer && range_err_q && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            sm_q        <= '0;
            y_q         <= '0;
            cin_q       <= 1'b0;
            s2_vld_q    <= 1'b0;
            x_q         <= '0;
            x_zero_q    <= 1'b0;
            range_err_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            if (in_xfer) begin
                s1_vld_q <= 1'b1;
                sm_q     <= sm;
                y_q      <= y;
                cin_q    <= cin;
            end else if (s2_adv) begin
                s1_vld_q <= 1'b0;
            end

            if (s2_adv) begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    x_q         <= x_d;
                    x_zero_q    <= x_zero_d;
                    range_err_q <= range_err_d;
                end
            end

            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign x         = x_q;
    assign x_zero    = x_zero_q;
    assign range_err = range_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_subtractor_pipe.sv
// Bench for subtractor_pipe: vector table, scoreboard monitor, stall/reset sequences.
module tb_subtractor_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   sm;
    logic [W-1:0] y;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] x;
    logic         x_zero;
    logic         range_err;
    logic [7:0]   err_cnt;

    subtractor_pipe #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sm(sm), .y(y), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .x_zero(x_zero), .range_err(range_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: {range_err, x_zero, x} from integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W:0] a, input logic [W-1:0] b, input logic c);
        int diff;
        logic [W-1:0] lo;
        logic er;
        diff = int'(a) - int'(b) - int'(c);
        lo   = diff[W-1:0];
        er   = (diff < 0) || (diff > (2**W - 1));
        return {er, (diff == 0), lo};
    endfunction

    // Scoreboard monitor: sampled on the falling edge, predicts the next rising edge.
    logic [W+1:0] sb_q[$];
    logic [W+1:0] exp_r;
    int  exp_cnt = 0;
    bit  armed   = 1'b0;
    int  xfer_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready_in_reset", in_ready, 0);
            sb_q.delete();
            exp_cnt = 0;
            armed   = 1'b1;
        end else if (armed) begin
            chk("err_cnt", err_cnt, exp_cnt);
            if (out_valid && out_ready) begin
                xfer_cnt++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_r = sb_q.pop_front();
                    chk("sb_x", x, exp_r[W-1:0]);
                    chk("sb_x_zero", x_zero, exp_r[W]);
                    chk("sb_range_err", range_err, exp_r[W+1]);
                    if (exp_r[W+1] && exp_cnt < 255) exp_cnt++;
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model(sm, y, cin));
        end
    end

    typedef struct {
        logic [W:0]   sm;
        logic [W-1:0] y;
        logic         cin;
        logic [W-1:0] ex;
        logic         ez;
        logic         er;
    } vec_t;

    vec_t tbl[9];

    task automatic send(input logic [W:0] a, input logic [W-1:0] b, input logic c);
        int n;
        in_valid = 1'b1; sm = a; y = b; cin = c;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 20);
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    int n;
    int acc;
    int first_c;
    int last_c;
    int cnt_c;
    logic [W-1:0] x_hold;
    logic [W:0]   d3_sm [3];
    logic [W-1:0] d3_y  [3];

    initial begin
        tbl[0] = '{9'd300, 8'd100, 1'b1, 8'd199, 1'b0, 1'b0};
        tbl[1] = '{9'd50,  8'd50,  1'b0, 8'd0,   1'b1, 1'b0};
        tbl[2] = '{9'd10,  8'd20,  1'b0, 8'd246, 1'b0, 1'b1};
        tbl[3] = '{9'd511, 8'd0,   1'b0, 8'd255, 1'b0, 1'b1};
        tbl[4] = '{9'd0,   8'd0,   1'b1, 8'd255, 1'b0, 1'b1};
        tbl[5] = '{9'd255, 8'd0,   1'b0, 8'd255, 1'b0, 1'b0};
        tbl[6] = '{9'd256, 8'd0,   1'b0, 8'd0,   1'b0, 1'b1};
        tbl[7] = '{9'd256, 8'd255, 1'b1, 8'd0,   1'b1, 1'b0};
        tbl[8] = '{9'd0,   8'd255, 1'b1, 8'd0,   1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sm = '0; y = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_x", x, 0);
        chk("rst_x_zero", x_zero, 0);
        chk("rst_range_err", range_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);
        @(posedge clk); #1;

        // Table vectors, one at a time on an empty pipe.
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].sm, tbl[i].y, tbl[i].cin);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 20);
            chk($sformatf("latency[%0d]", i), n, 2);
            chk($sformatf("tbl_x[%0d]", i), x, tbl[i].ex);
            chk($sformatf("tbl_x_zero[%0d]", i), x_zero, tbl[i].ez);
            chk($sformatf("tbl_range_err[%0d]", i), range_err, tbl[i].er);
            @(posedge clk); #1;
            if (i == 3) begin
                @(negedge clk);
                chk("err_cnt_after_4", err_cnt, 2);
                @(posedge clk); #1;
            end
        end

        // Back-to-back stream of 8.
        first_c = -1; last_c = -1; cnt_c = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) begin
                in_valid = 1'b1;
                sm = 9'($urandom_range(0, 511));
                y  = 8'($urandom_range(0, 255));
                cin = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 8) chk("stream_in_ready", in_ready, 1);
            if (out_valid && out_ready) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                cnt_c++;
            end
            @(posedge clk); #1;
        end
        chk("stream_count", cnt_c, 8);
        chk("stream_first", first_c, 2);
        chk("stream_span", last_c - first_c, 7);

        // Stall: 5 cycles out_ready=0 while offering 3 inputs.
        d3_sm[0] = 9'd400; d3_y[0] = 8'd17;
        d3_sm[1] = 9'd5;   d3_y[1] = 8'd9;
        d3_sm[2] = 9'd128; d3_y[2] = 8'd28;
        out_ready = 1'b0; acc = 0;
        in_valid = 1'b1; sm = d3_sm[0]; y = d3_y[0]; cin = 1'b0;
        x_hold = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) x_hold = x;
            if (c >= 2) begin
                chk("stall_out_valid", out_valid, 1);
                chk("stall_x_stable", x, x_hold);
                chk("stall_in_ready", in_ready, 0);
            end
            n = in_ready ? 1 : 0;
            @(posedge clk); #1;
            if (n == 1) begin
                acc++;
                sm = d3_sm[acc]; y = d3_y[acc];
            end
        end
        chk("stall_accepted", acc, 2);
        chk("stall_x_hold_val", x_hold, 8'd127);
        out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 20);
        chk("third_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stall_drained", sb_q.size(), 0);

        // Saturate the error counter.
        for (int i = 0; i < 260; i++) begin
            in_valid = 1'b1; sm = '0; y = '0; cin = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("err_cnt_sat", err_cnt, 255);
        @(posedge clk); #1;

        // Fill both stages, then a one-cycle reset.
        out_ready = 1'b0;
        in_valid = 1'b1; sm = 9'd77; y = 8'd7; cin = 1'b0;
        @(posedge clk); #1;
        sm = 9'd88;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        n = xfer_cnt;
        repeat (5) @(negedge clk);
        chk("no_stale_output", xfer_cnt - n, 0);
        chk("final_sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/subtractor_pipe.md
SUBTRACTOR_PIPE -- requirements
Module: subtractor_pipe

Interface
REQ-001 Parameter: W, default 8, operand width; the sum input is W+1 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  the input operand set is valid.
REQ-005 in_ready  output  1  the block accepts input this cycle.
REQ-006 sm  input  W+1  sum to be decomposed.
REQ-007 y  input  W  known addend.
REQ-008 cin  input  1  known carry-in.
REQ-009 out_valid  output  1  the result is valid.
REQ-010 out_ready  input  1  the downstream consumer accepts the result.
REQ-011 x  output  W  recovered addend, x = sm - y - cin, low W bits.
REQ-012 x_zero  output  1  the full-precision difference equals 0.
REQ-013 range_err  output  1  the full-precision difference is outside 0..2^W-1.
REQ-014 err_cnt  output  8  saturating count of accepted results that had range_err set.

Function
REQ-015 The block shall compute the difference in W+2-bit two's complement: d = {0,sm} - {00,y} - cin.
REQ-016 range_err shall be 1 when d is negative or when d is greater than 2^W-1.
  - Both conditions are checked on the sign bit and on bit W of d.
REQ-017 x shall equal d[W-1:0] whether or not range_err is set.
REQ-018 x_zero shall be 1 when d is exactly 0.
  - x_zero shall be 0 whenever range_err is 1, even if the low bits of d are zero.
REQ-019 The pipeline shall have two register stages.
  - Stage 1 captures sm, y and cin.
  - Stage 2 holds d and the derived flags.
  - Latency from input transfer (in_valid & in_ready) to out_valid is 2 cycles when the output is not stalled.
REQ-020 A transfer shall occur on any cycle where valid and ready are both 1.
  - Data presented without a matching ready shall not be consumed.
REQ-021 in_ready shall be 1 when stage 1 is empty, or when stage 1 is able to advance in the same cycle.
  - Stage 1 advances when stage 2 is empty or stage 2 is transferring out.
  - The throughput target is 1 operand set per cycle under continuous out_ready.
REQ-022 in_ready shall not depend combinationally on in_valid.
REQ-023 While out_valid=1 and out_ready=0, the outputs x, x_zero and range_err shall hold stable.
REQ-024 While out_valid=1 and out_ready=0, out_valid shall stay 1.
REQ-025 Each stage shall keep a valid bit.
  - A stage is loaded only on an upstream transfer.
  - A stage is cleared when it transfers onward and is not reloaded in the same cycle.
REQ-026 On a simultaneous output transfer and new input transfer, both stages shall advance in the same cycle.
  - No data is lost or duplicated.
REQ-027 err_cnt shall increment by 1 on each output transfer with range_err=1.
  - err_cnt shall hold at 255 once it reaches 255.
  - err_cnt shall not change on stalled cycles.
REQ-028 Boundary values shall produce these results:
  - sm=0, y=0, cin=1 gives d=-1, range_err=1, x=2^W-1.
  - sm=2^(W+1)-1, y=0, cin=0 gives range_err=1.
  - sm=2^W-1, y=0, cin=0 gives x=2^W-1, range_err=0.

Reset
REQ-029 While rst=1 at a clock edge, both stage valid bits shall clear.
  - out_valid=0, x=0, x_zero=0, range_err=0 and err_cnt=0.
REQ-030 in_ready shall be 0 during any cycle in which rst=1.
REQ-031 in_ready shall be 1 in the first cycle after rst deasserts.
REQ-032 A reset asserted mid-operation shall discard all in-flight results.
  - No output transfer is reported for operands accepted before the reset.

Verification
REQ-033 Reset, then apply sm=9'd300, y=8'd100, cin=1 with out_ready=1 -> two cycles later x=199, x_zero=0, range_err=0, err_cnt=0.
REQ-034 Apply sm=9'd50, y=8'd50, cin=0 -> x=0, x_zero=1, range_err=0.
REQ-035 Apply sm=9'd10, y=8'd20, cin=0, then sm=9'd511, y=0, cin=0 -> x=246 with range_err=1, then x=255 with range_err=1; err_cnt=2.
REQ-036 Stream 8 back-to-back operand sets with out_ready=1 -> 8 results in order on consecutive cycles, and in_ready is never 0.
REQ-037 Hold out_ready=0 for 5 cycles while offering 3 inputs:
  - exactly 2 are accepted, then in_ready=0;
  - x stays stable while stalled;
  - releasing out_ready drains both results in order, then the third is accepted.
REQ-038 Assert rst for 1 cycle while both stages are full -> next cycle out_valid=0, err_cnt=0, in_ready=1, and no stale result appears later.
